// File: rtl/fetch_pkg.sv
// Shared constants and helpers for the instruction-fetch stage.
// Contents: default prefetch depth, PC increment per instruction, counter-width helper.
package fetch_pkg;

  localparam int unsigned FETCH_DEPTH_DEFAULT = 4;
  localparam int unsigned PC_STEP             = 4;

  // Bits needed to hold values 0..max_val inclusive (never less than 1).
  function automatic int unsigned cnt_width(input int unsigned max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Circular-buffer FIFO used for both the prefetch buffer and the issue-PC tag queue.
// Ports:
//   clk, reset (async, active-low) - clock and reset
//   clear                          - synchronous flush, overrides push/pop
//   push, push_data                - enqueue one entry
//   pop                            - dequeue the head
//   head                           - entry at the head (undefined when empty)
//   count                          - number of valid entries
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int unsigned DEPTH = FETCH_DEPTH_DEFAULT,
  parameter int unsigned W     = 32
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          clear,
  input  logic                          push,
  input  logic [W-1:0]                  push_data,
  input  logic                          pop,
  output logic [W-1:0]                  head,
  output logic [cnt_width(DEPTH)-1:0]   count
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = cnt_width(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] rd_q, wr_q;
  logic [CW-1:0] count_q;
  logic          do_push, do_pop;

  // Pop on empty is ignored; push on full is accepted only alongside a pop.
  assign do_pop  = pop && (count_q != '0);
  assign do_push = push && ((count_q != CW'(DEPTH)) || do_pop);

  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
  endfunction

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_q    <= '0;
      wr_q    <= '0;
      count_q <= '0;
    end else if (clear) begin
      rd_q    <= '0;
      wr_q    <= '0;
      count_q <= '0;
    end else begin
      if (do_pop)  rd_q <= ptr_inc(rd_q);
      if (do_push) wr_q <= ptr_inc(wr_q);
      if (do_push && !do_pop)      count_q <= count_q + CW'(1);
      else if (!do_push && do_pop) count_q <= count_q - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !clear) mem[wr_q] <= push_data;
  end

  assign head  = mem[rd_q];
  assign count = count_q;

endmodule

// File: rtl/fetch_prefetch_unit.sv
// Instruction-fetch stage: owns the PC, issues requests to a variable-latency imem over a
// valid/ready handshake, buffers returned instructions with their PC, and hands them to
// decode. Redirects flush the buffer and mark every in-flight request for discard.
// Optional build macro: FETCH_PERF_CNT_EN adds saturating performance counters.
// Ports:
//   clk, reset (async, active-low)
//   req_valid/req_ready/req_addr   - imem request channel
//   rsp_valid/rsp_data             - in-order imem responses, no backpressure
//   id_stall                       - decode stall, head held
//   if_valid/if_pc/if_instr        - head of the prefetch buffer (zero when empty)
//   redirect/redirect_pc           - flush and restart fetch at redirect_pc (word aligned)
//   perf_* (FETCH_PERF_CNT_EN)     - stall, empty, redirect and dropped-response counts
module fetch_prefetch_unit
  import fetch_pkg::*;
#(
  parameter int unsigned    PC_W       = 9,
  parameter int unsigned    INS_W      = 32,
  parameter int unsigned    FIFO_DEPTH = FETCH_DEPTH_DEFAULT,
  parameter logic [PC_W-1:0] RESET_PC  = '0,
  parameter int unsigned    OUTST_MAX  = 2 * FIFO_DEPTH
) (
  input  logic             clk,
  input  logic             reset,
  output logic             req_valid,
  input  logic             req_ready,
  output logic [PC_W-1:0]  req_addr,
  input  logic             rsp_valid,
  input  logic [INS_W-1:0] rsp_data,
  input  logic             id_stall,
  output logic             if_valid,
  output logic [PC_W-1:0]  if_pc,
  output logic [INS_W-1:0] if_instr,
  input  logic             redirect,
  input  logic [PC_W-1:0]  redirect_pc
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]      perf_stall_cyc,
  output logic [31:0]      perf_empty_cyc,
  output logic [31:0]      perf_redirects,
  output logic [31:0]      perf_dropped
`endif
);

  localparam int unsigned CW  = cnt_width(OUTST_MAX);
  localparam int unsigned FCW = cnt_width(FIFO_DEPTH);
  localparam int unsigned SW  = CW + FCW;

  logic [PC_W-1:0]  fetch_pc_q;
  logic [CW-1:0]    drop_cnt_q;
  logic [CW-1:0]    out_cnt;
  logic [FCW-1:0]   fifo_cnt;
  logic [PC_W-1:0]  tag_pc;
  logic [PC_W+INS_W-1:0] buf_head;
  logic [PC_W-1:0]  head_pc;
  logic [INS_W-1:0] head_instr;
  logic [SW-1:0]    credit_sum;
  logic             issue_ok, req_fire, rsp_drop, rsp_push, pop;
  logic             unused_rpc_lsb;

  assign unused_rpc_lsb = ^redirect_pc[1:0];

  // Credit from registered state only: live requests plus buffered entries must leave room.
  assign credit_sum = (SW'(out_cnt) - SW'(drop_cnt_q)) + SW'(fifo_cnt);
  assign issue_ok   = !redirect && (out_cnt < CW'(OUTST_MAX)) && (credit_sum < SW'(FIFO_DEPTH));

  // Gated by the reset pin so nothing is requested while held in reset.
  assign req_valid = issue_ok && reset;
  assign req_addr  = fetch_pc_q;
  assign req_fire  = req_valid && req_ready;

  // A response arriving in a redirect cycle belongs to the old stream.
  assign rsp_drop = rsp_valid && ((drop_cnt_q != '0) || redirect);
  assign rsp_push = rsp_valid && !rsp_drop;

  assign if_valid = (fifo_cnt != '0);
  assign pop      = if_valid && !id_stall && !redirect;

  // The tag queue's occupancy is the outstanding-request count; it is never flushed
  // because stale responses still return in order and must retire their tags.
  fetch_fifo #(
    .DEPTH (OUTST_MAX),
    .W     (PC_W)
  ) u_tag_q (
    .clk       (clk),
    .reset     (reset),
    .clear     (1'b0),
    .push      (req_fire),
    .push_data (fetch_pc_q),
    .pop       (rsp_valid),
    .head      (tag_pc),
    .count     (out_cnt)
  );

  fetch_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     (PC_W + INS_W)
  ) u_buf (
    .clk       (clk),
    .reset     (reset),
    .clear     (redirect),
    .push      (rsp_push),
    .push_data ({tag_pc, rsp_data}),
    .pop       (pop),
    .head      (buf_head),
    .count     (fifo_cnt)
  );

  assign {head_pc, head_instr} = buf_head;
  assign if_pc    = if_valid ? head_pc : '0;
  assign if_instr = if_valid ? head_instr : '0;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fetch_pc_q <= RESET_PC;
      drop_cnt_q <= '0;
    end else if (redirect) begin
      fetch_pc_q <= {redirect_pc[PC_W-1:2], 2'b00};
      // Every live request becomes stale; the one returning now is already dropped.
      drop_cnt_q <= out_cnt - CW'(rsp_valid);
    end else begin
      if (req_fire) fetch_pc_q <= fetch_pc_q + PC_W'(PC_STEP);
      if (rsp_valid && (drop_cnt_q != '0)) drop_cnt_q <= drop_cnt_q - CW'(1);
    end
  end

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] stall_q, empty_q, redir_q, drop_q;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == '1) ? v : v + 32'd1;
  endfunction

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_q <= '0;
      empty_q <= '0;
      redir_q <= '0;
      drop_q  <= '0;
    end else begin
      if (if_valid && id_stall) stall_q <= sat_inc(stall_q);
      if (!if_valid)            empty_q <= sat_inc(empty_q);
      if (redirect)             redir_q <= sat_inc(redir_q);
      if (rsp_drop)             drop_q  <= sat_inc(drop_q);
    end
  end

  assign perf_stall_cyc = stall_q;
  assign perf_empty_cyc = empty_q;
  assign perf_redirects = redir_q;
  assign perf_dropped   = drop_q;
`endif

endmodule

// File: tb/tb_fetch_prefetch_unit.sv
// Self-checking bench for fetch_prefetch_unit: random imem latency, stall, ready and redirect
// traffic against a queue-based model of the fetch stream, plus directed scenarios.
module tb_fetch_prefetch_unit;

  localparam int unsigned PC_W  = 9;
  localparam int unsigned INS_W = 32;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned OMAX  = 8;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic             req_valid, req_ready;
  logic [PC_W-1:0]  req_addr;
  logic             rsp_valid;
  logic [INS_W-1:0] rsp_data;
  logic             id_stall;
  logic             if_valid;
  logic [PC_W-1:0]  if_pc;
  logic [INS_W-1:0] if_instr;
  logic             redirect;
  logic [PC_W-1:0]  redirect_pc;

  fetch_prefetch_unit #(
    .PC_W       (PC_W),
    .INS_W      (INS_W),
    .FIFO_DEPTH (DEPTH),
    .RESET_PC   ('0),
    .OUTST_MAX  (OMAX)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_addr    (req_addr),
    .rsp_valid   (rsp_valid),
    .rsp_data    (rsp_data),
    .id_stall    (id_stall),
    .if_valid    (if_valid),
    .if_pc       (if_pc),
    .if_instr    (if_instr),
    .redirect    (redirect),
    .redirect_pc (redirect_pc)
  );

  always #5 clk = ~clk;

  typedef struct { int unsigned pc; int unsigned gen; int unsigned due; } mreq_t;
  typedef struct { int unsigned pc; logic [31:0] instr; } ent_t;

  mreq_t       mem_q[$];   // requests accepted by imem, in order
  ent_t        mfifo[$];   // expected prefetch buffer contents
  int unsigned popped[$];  // PCs consumed by decode
  int unsigned m_pc, gen, cyc;
  int          n_vec, n_err;

  int unsigned ready_pct, stall_pct, redir_pct, lat_min, lat_max;
  bit          force_redir;
  int unsigned force_rpc;

  function automatic logic [31:0] instr_of(input int unsigned pc);
    return (pc * 32'h9E37_79B1) ^ 32'h0BAD_F00D;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // One clock cycle: drive inputs, compare outputs mid-cycle, advance the model at the edge.
  task automatic step();
    int unsigned live;
    bit          e_req, do_pop;
    int unsigned t;
    mreq_t       h;
    redirect    = force_redir || ($urandom_range(99) < redir_pct);
    redirect_pc = PC_W'(force_redir ? force_rpc : $urandom);
    id_stall    = ($urandom_range(99) < stall_pct);
    req_ready   = ($urandom_range(99) < ready_pct);
    if (mem_q.size() > 0 && mem_q[0].due <= cyc) begin
      rsp_valid = 1'b1;
      rsp_data  = instr_of(mem_q[0].pc);
    end else begin
      rsp_valid = 1'b0;
      rsp_data  = $urandom;
    end
    live = 0;
    foreach (mem_q[i]) if (mem_q[i].gen == gen) live++;
    e_req = !redirect && (mem_q.size() < OMAX) && (live + mfifo.size() < DEPTH);
    #3;
    chk("if_valid", 32'(if_valid), 32'(mfifo.size() > 0));
    chk("if_pc", 32'(if_pc), (mfifo.size() > 0) ? mfifo[0].pc : 0);
    chk("if_instr", if_instr, (mfifo.size() > 0) ? mfifo[0].instr : 32'h0);
    chk("req_valid", 32'(req_valid), 32'(e_req));
    chk("req_addr", 32'(req_addr), m_pc);
    @(posedge clk);
    t = cyc;
    cyc++;
    do_pop = (mfifo.size() > 0) && !id_stall && !redirect;
    if (do_pop) begin
      popped.push_back(mfifo[0].pc);
      void'(mfifo.pop_front());
    end
    if (rsp_valid) begin
      h = mem_q.pop_front();
      if (h.gen == gen && !redirect) mfifo.push_back(ent_t'{pc: h.pc, instr: instr_of(h.pc)});
    end
    if (redirect) begin
      mfifo.delete();
      gen++;
      m_pc = int'(redirect_pc) & ~3;
    end else if (e_req && req_ready) begin
      mem_q.push_back(mreq_t'{pc: m_pc, gen: gen, due: t + $urandom_range(lat_max, lat_min)});
      m_pc = (m_pc + 4) % (1 << PC_W);
    end
    #1;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic knobs(input int unsigned rdy, input int unsigned stl, input int unsigned rdr,
                       input int unsigned lmin, input int unsigned lmax);
    ready_pct = rdy; stall_pct = stl; redir_pct = rdr; lat_min = lmin; lat_max = lmax;
  endtask

  task automatic do_redirect(input int unsigned target);
    force_redir = 1'b1;
    force_rpc   = target;
    step();
    force_redir = 1'b0;
  endtask

  int unsigned base;

  initial begin
    n_vec = 0; n_err = 0; cyc = 0; gen = 0; m_pc = 0;
    force_redir = 1'b0; force_rpc = 0;
    req_ready = 1'b0; rsp_valid = 1'b0; rsp_data = '0; id_stall = 1'b0;
    redirect = 1'b0; redirect_pc = '0;
    #2;
    chk("rst_if_valid", 32'(if_valid), 32'd0);
    chk("rst_if_pc", 32'(if_pc), 32'd0);
    chk("rst_if_instr", if_instr, 32'd0);
    chk("rst_req_valid", 32'(req_valid), 32'd0);
    chk("rst_req_addr", 32'(req_addr), 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b1;

    // Zero-latency streaming: one instruction per cycle after two cycles of startup.
    knobs(100, 0, 0, 1, 1);
    run(20);
    for (int i = 0; i < 8; i++) chk("stream_pc", popped[i], 4 * i);

    // Long stall fills the buffer and exhausts credit, then drains in order.
    knobs(100, 100, 0, 1, 1);
    run(10);
    chk("stall_req_valid", 32'(req_valid), 32'd0);
    chk("stall_if_valid", 32'(if_valid), 32'd1);
    knobs(100, 0, 0, 1, 1);
    run(8);
    for (int i = 1; i < popped.size(); i++) chk("seq_contig", popped[i], popped[i-1] + 4);

    // Latency 3 with requests in flight, then redirect to 0x40.
    knobs(100, 0, 0, 3, 3);
    run(3);
    base = popped.size();
    do_redirect(32'h40);
    run(10);
    chk("redir_first", popped[base], 32'h40);
    chk("redir_second", popped[base+1], 32'h44);

    // Redirect coinciding with a response and a pop.
    knobs(100, 0, 0, 1, 1);
    run(4);
    do_redirect(32'h84);
    chk("redir_same_empty", 32'(if_valid), 32'd0);
    chk("redir_same_addr", 32'(req_addr), 32'h84);
    run(4);

    // PC wrap and redirect alignment.
    base = popped.size();
    do_redirect(32'h1F8);
    run(8);
    chk("wrap0", popped[base], 32'h1F8);
    chk("wrap1", popped[base+1], 32'h1FC);
    chk("wrap2", popped[base+2], 32'h000);
    base = popped.size();
    do_redirect(32'h103);
    chk("align_addr", 32'(req_addr), 32'h100);
    run(6);
    chk("align_pop", popped[base], 32'h100);

    // Random traffic.
    knobs(70, 30, 5, 1, 5);
    run(2000);

    // Asynchronous reset mid-burst.
    knobs(100, 0, 0, 3, 3);
    run(4);
    rsp_valid = 1'b0; redirect = 1'b0;
    reset = 1'b0;
    #1;
    chk("arst_if_valid", 32'(if_valid), 32'd0);
    chk("arst_if_pc", 32'(if_pc), 32'd0);
    chk("arst_if_instr", if_instr, 32'd0);
    chk("arst_req_valid", 32'(req_valid), 32'd0);
    chk("arst_req_addr", 32'(req_addr), 32'd0);
    mem_q.delete(); mfifo.delete(); m_pc = 0; gen++;
    @(posedge clk);
    #1;
    reset = 1'b1;
    knobs(80, 20, 3, 1, 4);
    run(200);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/fetch_prefetch_unit.md
Name: fetch_prefetch_unit

Overview:
Parametrised instruction-fetch stage for the 5-stage RV32 pipeline. It owns the PC and issues requests to a variable-latency instruction memory through a valid/ready handshake. Returned instructions are buffered in a prefetch FIFO and presented to the IF/ID boundary with their PC. It honours the decode stall (hazard unit) and branch/jump redirects (flush), and discards in-flight responses made stale by a redirect.

Parameters:
PC_W, 9, PC / instruction-address width in bits (≥3)
INS_W, 32, instruction width
FIFO_DEPTH, 4, prefetch entries; power of 2, ≥2
RESET_PC, 0, PC value loaded at reset
OUTST_MAX, 2*FIFO_DEPTH, cap on total issued-but-unreturned requests, including ones to be dropped

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-low reset
req_valid  out  1  fetch request valid
req_ready  in  1  imem accepts request
req_addr  out  PC_W  fetch address, bits [1:0] always 0
rsp_valid  in  1  imem response valid; in-order; no backpressure
rsp_data  in  INS_W  returned instruction
id_stall  in  1  decode stall; head not consumed
if_valid  out  1  FIFO head valid
if_pc  out  PC_W  PC of head
if_instr  out  INS_W  instruction at head
redirect  in  1  flush and restart fetch (branch taken / jump)
redirect_pc  in  PC_W  restart target; bits [1:0] ignored (forced 0)

Behaviour:
- Reset (reset=0, async): fetch_pc=RESET_PC, FIFO empty, out_cnt=0, drop_cnt=0. Outputs: if_valid=0, if_pc=0, if_instr=0, req_valid=0, req_addr=RESET_PC.
- State: fetch_pc; FIFO {pc, instr} with count; out_cnt (issued, not returned); drop_cnt (≤out_cnt, responses to discard); issue-PC queue tagging each live request.
- Credit: issue_ok = !redirect && out_cnt<OUTST_MAX && (out_cnt-drop_cnt)+fifo_count<FIFO_DEPTH. Uses registered state only; same-cycle pops/responses give no credit.
- req_valid = issue_ok; req_addr = fetch_pc. Handshake: req_valid && req_ready → fetch_pc += 4 (mod 2^PC_W, wraps to 0), out_cnt += 1. Once asserted, req_valid/req_addr stay stable until accepted unless redirect.
- Response: out_cnt -= 1. If drop_cnt>0 → discard, drop_cnt -= 1. Else push {tagged pc, rsp_data}; overflow is impossible by credit.
- Pop: if_valid && !id_stall && !redirect. if_pc/if_instr = head; both 0 when empty.
- Redirect (highest priority, same cycle): FIFO cleared; fetch_pc <= {redirect_pc[PC_W-1:2],2'b00}; no issue or pop that cycle. drop_cnt <= out_cnt − (rsp_valid?1:0), so every live request is dropped, and a response arriving that cycle is discarded. First new request is visible the next cycle.
- Simultaneous push+pop: count unchanged. Push into empty FIFO becomes visible next cycle.
- Latency: request accepted at t, response at t+k (k≥1), if_valid at t+k+1.
- Back-to-back redirects: each recomputes drop_cnt from current out_cnt. OUTST_MAX bounds counter width to $clog2(OUTST_MAX+1).
- Reset mid-operation: all state dropped immediately. A late response from an old request after reset release is the memory's responsibility; the block is specified only with imem reset alongside.

Optional Feature:
FETCH_PERF_CNT_EN
- Defined: adds 32-bit saturating outputs perf_stall_cyc (if_valid && id_stall), perf_empty_cyc (!if_valid, not in reset), perf_redirects, perf_dropped (discarded responses). All reset to 0.
- Undefined: ports and counters absent; behaviour otherwise identical.

Decomposition:
- Package fetch_pkg: FETCH_DEPTH_DEFAULT, PC_STEP=4, function clog2-safe counter width.
- Sub-module fetch_fifo (DEPTH, W): circular buffer with wrap-around rd/wr pointers, count, synchronous clear, push/pop, head output. The top level instantiates it for {pc,instr} and for the issue-PC tag queue.

Test Plan:
- Zero-latency streaming (req_ready=1, rsp k=1, id_stall=0) from RESET_PC=0 → if_pc sequence 0,4,8,… one per cycle after 2-cycle startup; out_cnt ≤ FIFO_DEPTH.
- id_stall=1 for 10 cycles → FIFO fills to 4, req_valid drops once credit is exhausted, head holds; release stall → 4 pops in order with no gap or duplicate.
- Latency k=3, three outstanding, redirect to 0x40 → three stale responses discarded, next if_pc=0x40, then 0x44.
- Redirect in same cycle as rsp_valid and as pop → response dropped, no pop counted, FIFO empty next cycle, req_addr=target.
- PC wrap: RESET_PC=0x1F8, PC_W=9 → if_pc 0x1F8, 0x1FC, 0x000; redirect_pc=0x103 → fetch at 0x100.
- Async reset asserted mid-burst with 2 outstanding → outputs zero immediately, first req_addr=RESET_PC after release.
